// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer driving all datapath control strobes of the 8-bit CPU
//
// Ports:
//   clk     system clock, all state changes on posedge
//   clr_n   asynchronous active-low reset; also forces every control output low
//   instr   instruction register contents, opcode = instr[7:4]
//   flag_c  registered carry flag, sampled in T2 of JC
//   flag_z  registered zero flag, sampled in T2 of JZ
//   hlt     halt strobe in HLT T2, then held high while halted
//   mi ri ro io ii ai ao eo su bi oi ce co j fi
//           datapath load/drive/ALU/PC control strobes
//   step    current T-state, for debug display
module control_sequencer #(
  parameter int MAX_STEPS    = 5,
  parameter bit FIXED_LENGTH = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] instr,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi,
  output logic [2:0] step
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [2:0] STEP_WRAP = 3'(MAX_STEPS - 1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] step_q;
  logic [2:0] step_nxt;
  logic [2:0] last_step;
  logic       halted_q;
  logic       halt_now;
  logic [3:0] opcode;

  assign opcode = instr[7:4];

  // The operand nibble only reaches the bus through the io strobe; it is
  // never decoded here.
  logic unused_operand;
  assign unused_operand = ^instr[3:0];

  assign halt_now = !halted_q && (step_q == T2) && (opcode == OP_HLT);

  always_comb begin
    last_step = T2;
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
  end

  always_comb begin
    step_nxt = step_q + 3'd1;
    if (halted_q || halt_now) begin
      step_nxt = step_q;
    end else if (FIXED_LENGTH) begin
      if (step_q == STEP_WRAP) step_nxt = T0;
    end else begin
      if (step_q == last_step) step_nxt = T0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q <= step_nxt;
      if (halt_now) halted_q <= 1'b1;
    end
  end

  assign step = step_q;

  // Steps past an opcode's final step fall through every case below, so
  // the idle padding in fixed-length mode needs no extra logic.
  always_comb begin
    hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0; io = 1'b0; ii = 1'b0;
    ai  = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0;
    ce  = 1'b0; co = 1'b0; j  = 1'b0; fi = 1'b0;
    if (!clr_n) begin
      // reset gates the decode directly so controls drop without a clock
    end else if (halted_q) begin
      hlt = 1'b1;
    end else begin
      case (step_q)
        T0: begin co = 1'b1; mi = 1'b1; end
        T1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
            OP_LDI: begin io = 1'b1; ai = 1'b1; end
            OP_JMP: begin io = 1'b1; j = 1'b1; end
            OP_JC:  begin io = flag_c; j = flag_c; end
            OP_JZ:  begin io = flag_z; j = flag_z; end
            OP_OUT: begin ao = 1'b1; oi = 1'b1; end
            OP_HLT: hlt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
            OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
            OP_STA:         begin ao = 1'b1; ri = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; end
            OP_SUB: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against a table-driven microcode model
//
// Ports: none (top-level bench)
module tb_control_sequencer;

  localparam int MAX_STEPS    = 5;
  localparam bit FIXED_LENGTH = 1'b0;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] instr;
  logic       flag_c, flag_z;
  logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  logic [2:0] step;
  logic [15:0] ctrl_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tab [16][8];
  int          op_len [16];

  control_sequencer #(.MAX_STEPS(MAX_STEPS), .FIXED_LENGTH(FIXED_LENGTH)) dut (
    .clk(clk), .clr_n(clr_n), .instr(instr), .flag_c(flag_c), .flag_z(flag_z),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
    .step(step)
  );

  assign ctrl_vec = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Microcode as a per-opcode list of step masks; conditional jumps are
  // resolved against the flags at lookup time.
  task automatic build_model();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 8; t++) tab[op][t] = 16'h0;
      tab[op][0] = CO | MI;
      tab[op][1] = RO | II | CE;
      op_len[op] = 3;
    end
    tab[1][2] = IO | MI; tab[1][3] = RO | AI;                          op_len[1] = 4;
    tab[2][2] = IO | MI; tab[2][3] = RO | BI; tab[2][4] = EO | AI | FI; op_len[2] = 5;
    tab[3][2] = IO | MI; tab[3][3] = RO | BI; tab[3][4] = EO | AI | FI | SU; op_len[3] = 5;
    tab[4][2] = IO | MI; tab[4][3] = AO | RI;                          op_len[4] = 4;
    tab[5][2] = IO | AI;
    tab[6][2] = IO | J;
    tab[7][2] = IO | J;
    tab[8][2] = IO | J;
    tab[14][2] = AO | OI;
    tab[15][2] = HLT;
  endtask

  task automatic check_step(input logic [3:0] op, input int t, input logic fc, input logic fz);
    logic [15:0] exp;
    logic [15:0] got;
    int drivers;
    exp = tab[op][t];
    if (t == 2 && ((op == 4'h7 && !fc) || (op == 4'h8 && !fz))) exp = 16'h0;
    got = ctrl_vec;
    if (op == 4'h3 && t == 3) got = got & ~SU;
    check_eq($sformatf("ctrl op=%h t=%0d c=%b z=%b", op, t, fc, fz), got, exp);
    drivers = int'(co) + int'(ro) + int'(io) + int'(ao) + int'(eo);
    check_eq($sformatf("one_driver op=%h t=%0d", op, t), 16'(drivers <= 1), 16'd1);
  endtask

  // Entered at a negedge with the DUT in T0; leaves at the negedge of the
  // next instruction's T0 (or halted), unless stop_at cuts it short.
  task automatic exec_instr(input logic [7:0] ins, input logic fc, input logic fz, input int stop_at);
    logic [3:0] op;
    int n;
    op = ins[7:4];
    n  = (op == 4'hF) ? 3 : (FIXED_LENGTH ? MAX_STEPS : op_len[op]);
    for (int t = 0; t < n; t++) begin
      if (t == 1) instr = ins;
      if (t == 2) begin flag_c = fc; flag_z = fz; end
      #1;
      check_eq($sformatf("step op=%h", op), 16'(step), 16'(t));
      check_step(op, t, fc, fz);
      if (t == 2 && (op == 4'h7 || op == 4'h8)) begin
        flag_c = ~fc; flag_z = ~fz;
        #1;
        check_step(op, t, ~fc, ~fz);
      end
      if (t == stop_at) return;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] ins;
    build_model();
    clr_n = 1'b0; instr = 8'h00; flag_c = 1'b0; flag_z = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset ctrl", ctrl_vec, 16'h0);
    check_eq("reset step", 16'(step), 16'd0);
    @(negedge clk);
    clr_n = 1'b1;

    exec_instr(8'h15, 1'b0, 1'b0, -1);
    exec_instr(8'h3E, 1'b0, 1'b0, -1);
    exec_instr(8'h74, 1'b0, 1'b0, -1);
    exec_instr(8'h74, 1'b1, 1'b0, -1);
    exec_instr(8'h83, 1'b0, 1'b0, -1);
    exec_instr(8'h83, 1'b0, 1'b1, -1);
    for (int op = 9; op <= 13; op++) exec_instr({4'(op), 4'h7}, 1'b1, 1'b1, -1);

    // reset in the middle of ADD T3
    exec_instr(8'h2A, 1'b0, 1'b0, 3);
    clr_n = 1'b0;
    #1;
    check_eq("mid-reset ctrl", ctrl_vec, 16'h0);
    check_eq("mid-reset step", 16'(step), 16'd0);
    @(negedge clk);
    clr_n = 1'b1;
    exec_instr(8'h42, 1'b0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF) ins[7:4] = 4'hE;
      exec_instr(ins, 1'($urandom), 1'($urandom), -1);
    end

    // halt, then hold for a while, then release via reset
    exec_instr(8'hF0, 1'b1, 1'b1, -1);
    for (int k = 0; k < 12; k++) begin
      instr = 8'($urandom); flag_c = 1'($urandom); flag_z = 1'($urandom);
      #1;
      check_eq("halted ctrl", ctrl_vec, HLT);
      check_eq("halted step", 16'(step), 16'd2);
      @(negedge clk);
    end
    #2;
    clr_n = 1'b0;
    #1;
    check_eq("unhalt ctrl", ctrl_vec, 16'h0);
    check_eq("unhalt step", 16'(step), 16'd0);
    @(negedge clk);
    clr_n = 1'b1;
    exec_instr(8'h5C, 1'b0, 1'b0, -1);
    exec_instr(8'hE1, 1'b0, 1'b0, -1);
    #1;
    check_eq("final step", 16'(step), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit CPU; it generates every datapath control strobe from the instruction register and the flags register.
- It runs a T-state counter: a fetch in T0–T1, then opcode-dependent execute steps.
- All A, B, out, instruction, RAM, MAR, ALU, flags and PC load/drive enables come from this block.

Parameters:
- MAX_STEPS, 5: number of T-states in the longest instruction (ADD/SUB); the counter wraps after step MAX_STEPS-1.
- FIXED_LENGTH, 0: 1 = every instruction occupies all MAX_STEPS steps, with unused steps idle; 0 = jump to T0 right after an instruction's last used step.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clr_n  input  1  asynchronous active-low reset.
- instr  input  8  instruction register contents; opcode = instr[7:4].
- flag_c  input  1  registered carry flag.
- flag_z  input  1  registered zero flag.
- hlt  output  1  halt strobe / halted indicator.
- mi  output  1  MAR load.
- ri  output  1  RAM write.
- ro  output  1  RAM drives bus.
- io  output  1  instruction register operand (instr[3:0]) drives bus.
- ii  output  1  instruction register load.
- ai  output  1  A register load.
- ao  output  1  A drives bus.
- eo  output  1  ALU drives bus.
- su  output  1  ALU subtract.
- bi  output  1  B register load.
- oi  output  1  out register load.
- ce  output  1  PC increment.
- co  output  1  PC drives bus.
- j  output  1  PC load from bus.
- fi  output  1  flags register load.
- step  output  3  current T-state, for debug display.

Behaviour:
- State: step counter (3 bits) and halted latch. Control outputs are a combinational decode of {step, opcode, flag_c, flag_z, halted}. Consumers latch on the same posedge that advances step.
- While clr_n is low: step=0, halted=0, and all control outputs are forced to 0. On the first posedge after release, T0 is active.
- Fetch, identical for all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
  - T2 onward decode the instr value loaded at the end of T1.
- Execute steps; the last listed step is the final step:
  - NOP 0x0: T2 none.
  - LDA 0x1: T2 io, mi; T3 ro, ai.
  - ADD 0x2: T2 io, mi; T3 ro, bi; T4 eo, ai, fi.
  - SUB 0x3: same as ADD, with su also asserted in T4 (su also high in T3 is permitted; it must be high in T4).
  - STA 0x4: T2 io, mi; T3 ao, ri.
  - LDI 0x5: T2 io, ai.
  - JMP 0x6: T2 io, j.
  - JC 0x7: T2 io, j only if flag_c=1, otherwise none.
  - JZ 0x8: T2 io, j only if flag_z=1, otherwise none.
  - OUT 0xE: T2 ao, oi.
  - HLT 0xF: T2 hlt.
  - 0x9–0xD: decoded as NOP.
- Step advance:
  - FIXED_LENGTH=0: next step = 0 if the current step is the final step, else step+1.
  - FIXED_LENGTH=1: next step = 0 at step MAX_STEPS-1, else step+1. Steps past the final step have all controls 0.
- Flags are sampled combinationally in T2 only. A flag change during T2 affects j in that same cycle.
- Halt:
  - On the posedge at the end of HLT T2, halted is set and step freezes at 2.
  - While halted: hlt=1 and every other output is 0.
  - Only clr_n clears halted.
- Reset mid-instruction: controls drop to 0 immediately (asynchronous); the sequencer restarts at T0 after release.
- Only one bus driver (co, ro, io, ao, eo) may be asserted in any step; the bench checks this as an assertion.

Test Plan:
- Reset then run, with instr updated to 0x15 (LDA 5) when ii fires → T0 co+mi; T1 ro+ii+ce; T2 io+mi; T3 ro+ai; then step=0. Total 4 cycles with FIXED_LENGTH=0, 5 cycles with FIXED_LENGTH=1.
- instr=0x3E (SUB 14) → T4 asserts eo, ai, fi, su; step returns to 0 after T4; exactly one bus driver in every step.
- JC 0x74 with flag_c=0, then again with flag_c=1 → first T2 has all controls 0; second T2 asserts io+j. Repeat JZ 0x83 with flag_z for the same result.
- HLT 0xF0 → hlt at T2, then hlt=1 with all others 0 and step=2 for 10+ cycles. Pulse clr_n low → hlt=0 and step=0 asynchronously; T0 resumes after release.
- Assert clr_n low during ADD T3 → all outputs 0 within the same cycle; after release, T0 co+mi. The next instruction is fetched cleanly.
- Opcodes 0x9–0xD → only the fetch strobes are seen; T2 is idle; no j, ri or hlt is ever asserted.
